// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port, holds on
// mem_ready, and drives the datapath controls. It also keeps a retired-
// instruction counter and halt/trap status.
// Optional: define MC_TIMEOUT_EN to trap when a memory wait reaches MEM_TIMEOUT.
module multicycle_control #(
  parameter int OPC_W       = 5,
  parameter int ALUOP_W     = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   inst,
  input  logic               immbit,
  input  logic               br_taken,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               fetch_req,
  output logic               ir_load,
  output logic               pc_write,
  output logic [1:0]         srcPC,
  output logic               Branch,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               ALUsrc,
  output logic               RegWrite,
  output logic               auipc,
  output logic               jump,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               flush,
  output logic               halted,
  output logic               trap,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_ECALL, C_EBREAK, C_FENCE, C_ILL
  } cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d, dec_cls;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              trap_q, trap_d;
  logic              retire;
  logic              alu_en;
  logic              mem_timeout;

`ifdef MC_TIMEOUT_EN
  logic [15:0]       wait_q, wait_d;

  // Wait counter: runs only while stalled in FETCH/MEM.
  // Any other state, or a completed handshake, returns it to zero.
  // That gives a clean count on every entry to FETCH or MEM.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
      wait_d = wait_q + 16'd1;
  end
  assign mem_timeout = (wait_q == 16'(MEM_TIMEOUT - 1)) && !mem_ready;
`else
  assign mem_timeout = 1'b0;
`endif

  // Opcode classifier.
  // Used in DECODE both to pick the next state and to latch the class.
  always_comb begin
    dec_cls = C_ILL;
    case (inst)
      OPC_W'(5'b01100): dec_cls = C_R;
      OPC_W'(5'b00100): dec_cls = C_I;
      OPC_W'(5'b01101): dec_cls = C_LUI;
      OPC_W'(5'b00101): dec_cls = C_AUIPC;
      OPC_W'(5'b00000): dec_cls = C_LOAD;
      OPC_W'(5'b01000): dec_cls = C_STORE;
      OPC_W'(5'b11000): dec_cls = C_BRANCH;
      OPC_W'(5'b11011): dec_cls = C_JAL;
      OPC_W'(5'b11001): dec_cls = C_JALR;
      OPC_W'(5'b11100): dec_cls = immbit ? C_EBREAK : C_ECALL;
      OPC_W'(5'b00011): dec_cls = C_FENCE;
      default:          dec_cls = C_ILL;
    endcase
  end

  // Next state, strobes and memory/regfile controls.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    retire    = 1'b0;
    alu_en    = 1'b0;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    srcPC     = 2'b00;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    jump      = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (mem_timeout) begin
          state_d  = S_TRAP;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          C_ILL:    state_d = S_TRAP;
          C_EBREAK: begin
            flush   = 1'b1;
            state_d = S_HALT;
          end
          C_ECALL, C_FENCE: begin
            pc_write = 1'b1;
            srcPC    = 2'b11;
            flush    = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_en = 1'b1;
        case (cls_q)
          C_BRANCH: begin
            Branch = 1'b1;
            if (br_taken) begin
              pc_write = 1'b1;
              srcPC    = 2'b01;
              flush    = 1'b1;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL, C_JALR: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            srcPC    = (cls_q == C_JAL) ? 2'b01 : 2'b10;
            flush    = 1'b1;
            state_d  = S_WB;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        alu_en   = 1'b1;
        MemRead  = (cls_q == C_LOAD);
        MemWrite = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (mem_timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        alu_en   = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = (cls_q == C_LOAD);
        jump     = (cls_q == C_JAL) || (cls_q == C_JALR);
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        // The ebreak retires when execution resumes.
        if (resume) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU class controls, held through EXEC, MEM and WB.
  always_comb begin
    ALUOp  = '0;
    ALUsrc = 1'b0;
    auipc  = 1'b0;
    if (alu_en) begin
      case (cls_q)
        C_R:      ALUOp = ALUOP_W'(3'b010);
        C_I:      begin ALUOp = ALUOP_W'(3'b011); ALUsrc = 1'b1; end
        C_LUI:    begin ALUOp = ALUOP_W'(3'b100); ALUsrc = 1'b1; end
        C_BRANCH: ALUOp = ALUOP_W'(3'b001);
        C_AUIPC:  begin ALUsrc = 1'b1; auipc = 1'b1; end
        C_LOAD, C_STORE, C_JAL, C_JALR: ALUsrc = 1'b1;
        default:  ALUOp = '0;
      endcase
    end
  end

  // Retire counter and sticky trap flag.
  always_comb begin
    retired_d = retired_q + CNT_W'(retire);
    trap_d    = trap_q | (state_d == S_TRAP);
  end

  // State, class, counter and trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

`ifdef MC_TIMEOUT_EN
  // Wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`endif

  assign retired = retired_q;
  assign trap    = trap_q;

endmodule
